// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle between execute/CSR/debug logic and the fetch redirect controller.
// The requester side (execute, CSR, debug) uses the master modport.
// The controller uses the slave modport.
interface fetch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            hazard_stall;
    logic            branch_req;
    logic [XLEN-1:0] branch_target;
    logic            trap_req;
    logic [XLEN-1:0] mtvec;
    logic            mret_req;
    logic [XLEN-1:0] mepc;
    logic            irq_pending;
    logic            irq_enable;
    logic            dbg_halt_req;
    logic [XLEN-1:0] dbg_resume_pc;
    logic [1:0]      pcsel;
    logic [XLEN-1:0] target;
    logic            fe_stall;
    logic            flush;
    logic            irq_ack;
    logic            halt_ack;

    modport master (
        output hazard_stall, branch_req, branch_target, trap_req, mtvec,
               mret_req, mepc, irq_pending, irq_enable, dbg_halt_req, dbg_resume_pc,
        input  pcsel, target, fe_stall, flush, irq_ack, halt_ack
    );

    modport slave (
        input  hazard_stall, branch_req, branch_target, trap_req, mtvec,
               mret_req, mepc, irq_pending, irq_enable, dbg_halt_req, dbg_resume_pc,
        output pcsel, target, fe_stall, flush, irq_ack, halt_ack
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates boot, debug halt/resume, trap, mret,
// interrupt and branch redirects (one per cycle) for the two-stage front end.
// It drives PC select/target, front-end stall and the squash flush.
// Every output is registered from the next state, so it describes the state being entered.
module fetch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    fetch_redirect_ctrl_if.slave bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_ZERO   = 2'b01;
    localparam logic [1:0] PCSEL_TARGET = 2'b10;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_REDIRECT,
        ST_FLUSH,
        ST_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            trap_pend_q, trap_pend_d;
    logic            halt_pend_q, halt_pend_d;
    // BOOT is held for exactly one visible cycle after reset release.
    // This flag records that the BOOT outputs have been issued.
    logic            boot_done_q, boot_done_d;

    logic [1:0]      pcsel_q, pcsel_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            fe_stall_q, fe_stall_d;
    logic            flush_q, flush_d;
    logic            irq_ack_q, irq_ack_d;
    logic            halt_ack_q, halt_ack_d;

    logic [XLEN-1:0] redir_addr;
    logic            irq_win;
    logic            irq_ok;
    logic            leave_squash;

    assign irq_ok = bus.irq_pending && bus.irq_enable;

    // State, pending flags, flush counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_BOOT;
            cnt_q       <= '0;
            trap_pend_q <= 1'b0;
            halt_pend_q <= 1'b0;
            boot_done_q <= 1'b0;
            pcsel_q     <= PCSEL_SEQ;
            target_q    <= '0;
            fe_stall_q  <= 1'b1;
            flush_q     <= 1'b1;
            irq_ack_q   <= 1'b0;
            halt_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trap_pend_q <= trap_pend_d;
            halt_pend_q <= halt_pend_d;
            boot_done_q <= boot_done_d;
            pcsel_q     <= pcsel_d;
            target_q    <= target_d;
            fe_stall_q  <= fe_stall_d;
            flush_q     <= flush_d;
            irq_ack_q   <= irq_ack_d;
            halt_ack_q  <= halt_ack_d;
        end
    end

    // Next state: request arbitration, pending-flag bookkeeping and flush timing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trap_pend_d  = trap_pend_q;
        halt_pend_d  = halt_pend_q;
        boot_done_d  = boot_done_q;
        redir_addr   = '0;
        irq_win      = 1'b0;
        leave_squash = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (!boot_done_q) begin
                    boot_done_d = 1'b1;
                end else if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.dbg_halt_req) begin
                    // Halt wins. A simultaneous trap is remembered, but HALTED drops it.
                    state_d     = ST_HALTED;
                    trap_pend_d = trap_pend_q | bus.trap_req;
                end else if (bus.trap_req || trap_pend_q) begin
                    state_d     = ST_REDIRECT;
                    redir_addr  = bus.mtvec;
                    trap_pend_d = 1'b0;
                end else if (bus.mret_req) begin
                    state_d    = ST_REDIRECT;
                    redir_addr = bus.mepc;
                end else if (irq_ok) begin
                    state_d    = ST_REDIRECT;
                    redir_addr = bus.mtvec;
                    irq_win    = 1'b1;
                end else if (bus.branch_req) begin
                    state_d    = ST_REDIRECT;
                    redir_addr = bus.branch_target;
                end
            end

            ST_REDIRECT, ST_FLUSH: begin
                // Branches and mret are from squashed younger slots; traps/halts are kept.
                trap_pend_d = trap_pend_q | bus.trap_req;
                halt_pend_d = halt_pend_q | bus.dbg_halt_req;
                if (state_q == ST_REDIRECT) begin
                    leave_squash = (FLUSH_CYCLES == 1);
                end else begin
                    leave_squash = (cnt_q == CNT_LAST);
                end

                if (!leave_squash) begin
                    state_d = ST_FLUSH;
                    cnt_d   = (state_q == ST_REDIRECT) ? CNT_ONE : cnt_q + CNT_ONE;
                end else if (halt_pend_d) begin
                    state_d     = ST_HALTED;
                    halt_pend_d = 1'b0;
                end else if (trap_pend_d) begin
                    state_d     = ST_REDIRECT;
                    redir_addr  = bus.mtvec;
                    trap_pend_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_HALTED: begin
                trap_pend_d = 1'b0;
                halt_pend_d = 1'b0;
                if (!bus.dbg_halt_req) begin
                    state_d    = ST_REDIRECT;
                    redir_addr = bus.dbg_resume_pc;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output values for the state being entered. These are registered above.
    always_comb begin
        pcsel_d    = PCSEL_SEQ;
        target_d   = target_q;
        fe_stall_d = 1'b0;
        flush_d    = 1'b0;
        irq_ack_d  = 1'b0;
        halt_ack_d = 1'b0;

        case (state_d)
            ST_BOOT: begin
                pcsel_d = PCSEL_ZERO;
                flush_d = 1'b1;
            end
            ST_RUN: begin
                fe_stall_d = bus.hazard_stall;
            end
            ST_REDIRECT: begin
                // A redirect overrides any hazard stall so the new PC is fetched.
                pcsel_d   = PCSEL_TARGET;
                target_d  = redir_addr;
                flush_d   = 1'b1;
                irq_ack_d = irq_win;
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
            end
            ST_HALTED: begin
                fe_stall_d = 1'b1;
                flush_d    = 1'b1;
                halt_ack_d = 1'b1;
            end
            default: begin
                fe_stall_d = 1'b1;
                flush_d    = 1'b1;
            end
        endcase
    end

    assign bus.pcsel    = pcsel_q;
    assign bus.target   = target_q;
    assign bus.fe_stall = fe_stall_q;
    assign bus.flush    = flush_q;
    assign bus.irq_ack  = irq_ack_q;
    assign bus.halt_ack = halt_ack_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed testbench for fetch_redirect_ctrl with hand-computed expected values.
module tb_fetch_redirect_ctrl;
    logic clk;
    logic nrst;
    int   err_cnt;
    int   chk_cnt;

    fetch_redirect_ctrl_if #(.XLEN(32)) bus ();

    fetch_redirect_ctrl #(
        .XLEN(32),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] pcsel, input logic flush,
                           input logic stall);
        chk({tag, ".pcsel"}, 32'(bus.pcsel), 32'(pcsel));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(flush));
        chk({tag, ".fe_stall"}, 32'(bus.fe_stall), 32'(stall));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        nrst = 1'b0;
        bus.hazard_stall  = 1'b0;
        bus.branch_req    = 1'b0;
        bus.branch_target = 32'h0;
        bus.trap_req      = 1'b0;
        bus.mtvec         = 32'h100;
        bus.mret_req      = 1'b0;
        bus.mepc          = 32'h300;
        bus.irq_pending   = 1'b0;
        bus.irq_enable    = 1'b0;
        bus.dbg_halt_req  = 1'b0;
        bus.dbg_resume_pc = 32'h0;

        // 1: reset values, then BOOT, one FLUSH cycle, RUN
        tick();
        tick();
        chk_out("rst", 2'b00, 1'b1, 1'b1);
        chk("rst.target", bus.target, 32'h0);
        chk("rst.halt_ack", 32'(bus.halt_ack), 32'h0);
        chk("rst.irq_ack", 32'(bus.irq_ack), 32'h0);
        nrst = 1'b1;
        tick();
        chk_out("boot", 2'b01, 1'b1, 1'b0);
        tick();
        chk_out("boot_flush", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("boot_run", 2'b00, 1'b0, 1'b0);

        // 2: branch redirect to 0x40, flush held two cycles
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        bus.branch_req = 1'b0;
        chk_out("br_redir", 2'b10, 1'b1, 1'b0);
        chk("br_redir.target", bus.target, 32'h40);
        tick();
        chk_out("br_flush", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("br_run", 2'b00, 1'b0, 1'b0);

        // 3: trap beats branch on the same edge; branch is lost
        bus.trap_req = 1'b1;
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h44;
        tick();
        bus.trap_req = 1'b0;
        bus.branch_req = 1'b0;
        chk_out("tb_redir", 2'b10, 1'b1, 1'b0);
        chk("tb_redir.target", bus.target, 32'h100);
        tick();
        tick();
        chk_out("tb_run", 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("tb_no_branch", 2'b00, 1'b0, 1'b0);

        // mret beats branch and redirects to mepc
        bus.mret_req = 1'b1;
        bus.branch_req = 1'b1;
        tick();
        bus.mret_req = 1'b0;
        bus.branch_req = 1'b0;
        chk("mret.target", bus.target, 32'h300);
        tick();
        tick();
        chk_out("mret_run", 2'b00, 1'b0, 1'b0);

        // 4: trap during FLUSH causes a second redirect right after flush
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        bus.branch_req = 1'b0;
        chk("t4_redir.target", bus.target, 32'h40);
        tick();
        chk_out("t4_flush", 2'b00, 1'b1, 1'b0);
        bus.trap_req = 1'b1;
        tick();
        bus.trap_req = 1'b0;
        chk_out("t4_redir2", 2'b10, 1'b1, 1'b0);
        chk("t4_redir2.target", bus.target, 32'h100);
        tick();
        chk_out("t4_flush2", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("t4_run", 2'b00, 1'b0, 1'b0);

        // 5: masked irq ignored, enabled irq redirects with a single irq_ack
        bus.mtvec = 32'h200;
        bus.irq_pending = 1'b1;
        bus.hazard_stall = 1'b1;
        tick();
        chk_out("irq_masked", 2'b00, 1'b0, 1'b1);
        tick();
        chk_out("irq_masked2", 2'b00, 1'b0, 1'b1);
        bus.irq_enable = 1'b1;
        tick();
        bus.irq_pending = 1'b0;
        chk_out("irq_redir", 2'b10, 1'b1, 1'b0);
        chk("irq_redir.target", bus.target, 32'h200);
        chk("irq_redir.irq_ack", 32'(bus.irq_ack), 32'h1);
        tick();
        chk("irq_flush.irq_ack", 32'(bus.irq_ack), 32'h0);
        chk_out("irq_flush", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("irq_run_stall", 2'b00, 1'b0, 1'b1);
        bus.hazard_stall = 1'b0;
        tick();
        chk_out("irq_run", 2'b00, 1'b0, 1'b0);

        // 6: debug halt for 5 cycles with a trap ignored while halted, then resume to 0x80
        bus.dbg_halt_req = 1'b1;
        bus.dbg_resume_pc = 32'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) bus.trap_req = 1'b1;
            if (i == 3) bus.trap_req = 1'b0;
            chk($sformatf("halt%0d.halt_ack", i), 32'(bus.halt_ack), 32'h1);
            chk($sformatf("halt%0d.fe_stall", i), 32'(bus.fe_stall), 32'h1);
        end
        bus.dbg_halt_req = 1'b0;
        tick();
        chk_out("resume", 2'b10, 1'b1, 1'b0);
        chk("resume.target", bus.target, 32'h80);
        chk("resume.halt_ack", 32'(bus.halt_ack), 32'h0);
        tick();
        chk_out("resume_flush", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("resume_run", 2'b00, 1'b0, 1'b0);

        // nrst pulse in FLUSH restarts the boot sequence
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        bus.branch_req = 1'b0;
        tick();
        chk_out("pre_rst_flush", 2'b00, 1'b1, 1'b0);
        nrst = 1'b0;
        #2;
        chk_out("async_rst", 2'b00, 1'b1, 1'b1);
        chk("async_rst.target", bus.target, 32'h0);
        nrst = 1'b1;
        tick();
        chk_out("reboot", 2'b01, 1'b1, 1'b0);
        tick();
        chk_out("reboot_flush", 2'b00, 1'b1, 1'b0);
        tick();
        chk_out("reboot_run", 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
